// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32I major
// opcodes, controller FSM encodings, forwarding select codes, and
// register-usage decode helpers.
package pipe_ctrl_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;

    // Controller states, visible on the state output
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LD_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    // Operand forwarding selects
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // True when the instruction reads rs1
    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_STORE) ||
               (op == OP_LOAD) || (op == OP_ARI_RTYPE) || (op == OP_ARI_ITYPE);
    endfunction

    // True when the instruction reads rs2
    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_ARI_RTYPE);
    endfunction

endpackage

// File: rtl/pipe_ctrl_fwd.sv
// Forwarding select for one decode-stage source operand. The EX result
// wins over WB (it is younger); a load in EX cannot forward because its
// data does not exist yet -- that case is covered by the load-use stall.
module pipe_ctrl_fwd
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_adr,
    input  logic       i_ex_valid,
    input  logic       i_ex_we,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_is_load,
    input  logic       i_wb_valid,
    input  logic       i_wb_we,
    input  logic [4:0] i_wb_rd,
    output logic [1:0] o_fwd_sel
);

    // Priority compare: EX bypass, then WB bypass, else register file
    always_comb begin
        o_fwd_sel = FWD_NONE;
        if (i_ex_valid && i_ex_we && (i_ex_rd != 5'd0) &&
            (i_ex_rd == i_id_adr) && !i_ex_is_load) begin
            o_fwd_sel = FWD_EX;
        end else if (i_wb_valid && i_wb_we && (i_wb_rd != 5'd0) &&
                     (i_wb_rd == i_id_adr)) begin
            o_fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stage enables, bubbles and squashes for
// load-use hazards, data-memory waits, redirects and fetch misses, plus
// operand forwarding selects and a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [4:0]  id_adr1,
    input  logic [4:0]  id_adr2,
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [4:0]  ex_rd,
    input  logic        ex_we,
    input  logic        ex_br_taken,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        wb_we,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        id_kill,
    output logic        if_kill,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [31:0] stall_cycles
);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_stall_cycles;
    logic        w_mem_op;
    logic        w_ex_is_load;
    logic        w_load_use;
    logic        w_decide;
    logic [4:0]  w_id_adr [2];
    logic [1:0]  w_fwd_sel [2];

    assign w_ex_is_load = ex_valid && (ex_opcode == OP_LOAD);
    assign w_mem_op     = ex_valid && ((ex_opcode == OP_LOAD) || (ex_opcode == OP_STORE));
    assign w_load_use   = id_valid && w_ex_is_load && (ex_rd != 5'd0) &&
                          ((uses_rs1(id_opcode) && (id_adr1 == ex_rd)) ||
                           (uses_rs2(id_opcode) && (id_adr2 == ex_rd)));

    // One forwarding comparator per source operand (a = rs1, b = rs2)
    assign w_id_adr[0] = id_adr1;
    assign w_id_adr[1] = id_adr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            pipe_ctrl_fwd u_fwd (
                .i_id_adr     (w_id_adr[gi]),
                .i_ex_valid   (ex_valid),
                .i_ex_we      (ex_we),
                .i_ex_rd      (ex_rd),
                .i_ex_is_load (w_ex_is_load),
                .i_wb_valid   (wb_valid),
                .i_wb_we      (wb_we),
                .i_wb_rd      (wb_rd),
                .o_fwd_sel    (w_fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_a = w_fwd_sel[0];
    assign fwd_b = w_fwd_sel[1];

    // Next-state and enable/kill decode. The cycle a memory wait ends is
    // treated like a RUN cycle so a redirect or load-use arriving with
    // the completing access is still honoured.
    always_comb begin
        w_state_next = r_state;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        id_kill      = 1'b0;
        if_kill      = 1'b0;
        w_decide     = 1'b0;

        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            id_kill      = 1'b1;
            if_kill      = 1'b1;
            w_state_next = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_op && !dmem_ready) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        w_state_next = ST_MEM_WAIT;
                    end else begin
                        w_decide = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!dmem_ready) begin
                        pc_en    = 1'b0;
                        if_id_en = 1'b0;
                        id_ex_en = 1'b0;
                    end else begin
                        w_decide = 1'b1;
                    end
                end
                ST_LD_STALL: begin
                    w_state_next = ST_RUN;
                end
                ST_FLUSH: begin
                    if_kill      = 1'b1;
                    w_state_next = ST_RUN;
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase

            if (w_decide) begin
                if (ex_br_taken) begin
                    id_kill      = 1'b1;
                    w_state_next = ST_FLUSH;
                end else if (w_load_use) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_kill      = 1'b1;
                    w_state_next = ST_LD_STALL;
                end else if (!imem_ready) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_kill      = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
        end else if (!pc_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign state        = r_state;
    assign stall_cycles = r_stall_cycles;

endmodule
